// File: rtl/vn_pkg.sv
// Shared constants for the stochastic variable-node edge controller.
// Holds the LFSR width, tap mask, default seed and hold-counter width.
package vn_pkg;

    localparam int LFSR_W = 8;

    // Fibonacci taps x^8+x^6+x^5+x^4+1 -> state bits 7,5,4,3
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

    localparam logic [LFSR_W-1:0] LFSR_SEED = 8'hA5;

    localparam int HC_W = 16;

    function automatic logic [LFSR_W-1:0] lfsr_next(
        input logic [LFSR_W-1:0] s
    );
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/vn_lfsr.sv
// 8-bit Fibonacci LFSR with synchronous load and advance enable.
// Ports: i_clk, i_rst_n (async low), i_load, i_en, i_seed, o_state.
module vn_lfsr
    import vn_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = LFSR_SEED
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic              i_en,
    input  logic [LFSR_W-1:0] i_seed,
    output logic [LFSR_W-1:0] o_state
);

    logic [LFSR_W-1:0] r_state;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= SEED;
        end else if (i_load) begin
            r_state <= i_seed;
        end else if (i_en) begin
            r_state <= lfsr_next(r_state);
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/vn_edge_ctrl.sv
// Stochastic variable-node edge controller: regular/hold decision,
// edge-memory fill tracking and random edge-memory read address.
// Ports: CLK, RESET (async low), EN, INIT, LLR_BIT, IN_BITS, EM_OUT ->
//        OUT, EM_TRIG, EM_IN, SEL, HOLD, FILLED
//        [+ HOLD_CNT when VN_EDGE_HOLD_STAT_EN is defined].
module vn_edge_ctrl
    import vn_pkg::*;
#(
    parameter int                DV   = 3,
    parameter int                N    = 8,
    parameter int                NS   = 3,
    parameter logic [LFSR_W-1:0] SEED = LFSR_SEED
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          EN,
    input  logic          INIT,
    input  logic          LLR_BIT,
    input  logic [DV-2:0] IN_BITS,
    input  logic          EM_OUT,
    output logic          OUT,
    output logic          EM_TRIG,
    output logic          EM_IN,
    output logic [NS-1:0] SEL,
    output logic          HOLD,
    output logic          FILLED
`ifdef VN_EDGE_HOLD_STAT_EN
    ,
    output logic [HC_W-1:0] HOLD_CNT
`endif
);

    localparam int CW = $clog2(N + 1);

    logic [DV-1:0]     w_bits;
    logic              w_regular;
    logic              w_adv;
    logic [LFSR_W-1:0] w_lfsr;
    logic              w_unused_lfsr;
    logic [NS:0]       w_sel_ext;

    logic [CW-1:0]     r_cnt;
    logic              r_filled;
    logic              r_out;
    logic              r_trig;
    logic              r_em_in;
    logic              r_hold;

    assign w_bits    = {LLR_BIT, IN_BITS};
    assign w_regular = (&w_bits) | ~(|w_bits);
    assign w_adv     = EN & ~INIT;

    vn_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .i_clk   (CLK),
        .i_rst_n (RESET),
        .i_load  (INIT),
        .i_en    (EN),
        .i_seed  (SEED),
        .o_state (w_lfsr)
    );

    assign w_unused_lfsr = ^w_lfsr;

    // Fold out-of-range addresses back into 0..N-1
    always_comb begin
        w_sel_ext = {1'b0, w_lfsr[NS-1:0]};
        SEL       = w_lfsr[NS-1:0];
        if (w_sel_ext >= (NS+1)'(N)) begin
            SEL = w_lfsr[NS-1:0] - NS'(N);
        end
    end

    // Fill count saturates at N; FILLED tracks the post-update count
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_cnt    <= '0;
            r_filled <= 1'b0;
        end else if (INIT) begin
            r_cnt    <= '0;
            r_filled <= 1'b0;
        end else if (EN && w_regular) begin
            if (r_cnt != CW'(N)) begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_filled <= (r_cnt >= CW'(N - 1));
        end
    end

    // Hold uses the pre-update FILLED, so EM_OUT only after a full fill
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_out   <= 1'b0;
            r_trig  <= 1'b0;
            r_em_in <= 1'b0;
            r_hold  <= 1'b0;
        end else if (INIT) begin
            r_out  <= 1'b0;
            r_trig <= 1'b0;
            r_hold <= 1'b0;
        end else if (w_adv) begin
            if (w_regular) begin
                r_out   <= LLR_BIT;
                r_em_in <= LLR_BIT;
                r_trig  <= 1'b1;
                r_hold  <= 1'b0;
            end else begin
                r_out  <= r_filled ? EM_OUT : LLR_BIT;
                r_trig <= 1'b0;
                r_hold <= 1'b1;
            end
        end else begin
            r_trig <= 1'b0;
        end
    end

`ifdef VN_EDGE_HOLD_STAT_EN
    logic [HC_W-1:0] r_hcnt;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_hcnt <= '0;
        end else if (INIT) begin
            r_hcnt <= '0;
        end else if (w_adv && !w_regular && (r_hcnt != '1)) begin
            r_hcnt <= r_hcnt + 1'b1;
        end
    end

    assign HOLD_CNT = r_hcnt;
`endif

    assign OUT     = r_out;
    assign EM_TRIG = r_trig;
    assign EM_IN   = r_em_in;
    assign HOLD    = r_hold;
    assign FILLED  = r_filled;

endmodule

// File: tb/tb_vn_edge_ctrl.sv
// Self-checking bench for vn_edge_ctrl against a behavioural model.
// Optional VN_EDGE_HOLD_STAT_EN adds HOLD_CNT checks.
module tb_vn_edge_ctrl;

    localparam int DV = 3;
    localparam int N  = 8;
    localparam int NS = 3;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          EN;
    logic          INIT;
    logic          LLR_BIT;
    logic [DV-2:0] IN_BITS;
    logic          EM_OUT;
    logic          OUT;
    logic          EM_TRIG;
    logic          EM_IN;
    logic [NS-1:0] SEL;
    logic          HOLD;
    logic          FILLED;
`ifdef VN_EDGE_HOLD_STAT_EN
    logic [15:0]   HOLD_CNT;
`endif

    vn_edge_ctrl #(
        .DV   (DV),
        .N    (N),
        .NS   (NS),
        .SEED (8'hA5)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .EN       (EN),
        .INIT     (INIT),
        .LLR_BIT  (LLR_BIT),
        .IN_BITS  (IN_BITS),
        .EM_OUT   (EM_OUT),
        .OUT      (OUT),
        .EM_TRIG  (EM_TRIG),
        .EM_IN    (EM_IN),
        .SEL      (SEL),
        .HOLD     (HOLD),
        .FILLED   (FILLED)
`ifdef VN_EDGE_HOLD_STAT_EN
        ,
        .HOLD_CNT (HOLD_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_pass = 0;

    // Behavioural model state
    bit       m_out;
    bit       m_trig;
    bit       m_emin;
    bit       m_hold;
    int       m_cnt;
    bit [7:0] m_lfsr;
    int       m_hcnt;

    function automatic bit [7:0] lfsr_adv(input bit [7:0] s);
        bit fb;
        fb = s[7] ^ s[5] ^ s[4] ^ s[3];
        return {s[6:0], fb};
    endfunction

    function automatic int exp_sel();
        int v;
        v = m_lfsr % (1 << NS);
        if (v >= N) v = v - N;
        return v;
    endfunction

    function automatic bit m_filled();
        return m_cnt == N;
    endfunction

    function automatic logic [NS+4:0] exp_vec();
        return {m_out, m_trig, m_emin, m_hold, m_filled(), NS'(exp_sel())};
    endfunction

    function automatic logic [NS+4:0] act_vec();
        return {OUT, EM_TRIG, EM_IN, HOLD, FILLED, SEL};
    endfunction

    task automatic model_reset();
        m_out  = 0;
        m_trig = 0;
        m_emin = 0;
        m_hold = 0;
        m_cnt  = 0;
        m_lfsr = 8'hA5;
        m_hcnt = 0;
    endtask

    // Drive one cycle of inputs, advance the model, land 1ns after edge
    task automatic cyc(input bit en, input bit init, input bit llr,
                       input logic [DV-2:0] inb, input bit emo);
        bit agree;
        bit was_filled;
        EN      = en;
        INIT    = init;
        LLR_BIT = llr;
        IN_BITS = inb;
        EM_OUT  = emo;
        @(posedge CLK);
        agree      = (inb == {(DV-1){llr}});
        was_filled = m_filled();
        if (init) begin
            m_cnt  = 0;
            m_out  = 0;
            m_hold = 0;
            m_trig = 0;
            m_lfsr = 8'hA5;
            m_hcnt = 0;
        end else if (en) begin
            m_lfsr = lfsr_adv(m_lfsr);
            if (agree) begin
                m_out  = llr;
                m_emin = llr;
                m_trig = 1;
                m_hold = 0;
                if (m_cnt < N) m_cnt++;
            end else begin
                m_out  = was_filled ? emo : llr;
                m_trig = 0;
                m_hold = 1;
                if (m_hcnt < 16'hFFFF) m_hcnt++;
            end
        end else begin
            m_trig = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        RESET = 0; EN = 0; INIT = 0;
        LLR_BIT = 0; IN_BITS = '0; EM_OUT = 0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        n_chk++;
        if (act_vec() !== exp_vec())
            $display("FAIL reset_state got %b want %b", act_vec(), exp_vec());
        else n_pass++;
        RESET = 1;
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 1, 2'b11, 1);
            n_chk++;
            if (act_vec() !== exp_vec() || SEL !== 3'b101)
                $display("FAIL idle_%0d got %b want %b", i, act_vec(), exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_hold_prefill();
        cyc(1, 0, 0, 2'b10, 1);
        n_chk++;
        if (OUT !== 1'b0 || HOLD !== 1'b1 || EM_TRIG !== 1'b0)
            $display("FAIL hold_prefill got out=%b hold=%b trig=%b want 0 1 0",
                     OUT, HOLD, EM_TRIG);
        else n_pass++;
        n_chk++;
        if (act_vec() !== exp_vec())
            $display("FAIL hold_prefill_vec got %b want %b", act_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            cyc(1, 0, 1, 2'b11, 1'($urandom));
            n_chk++;
            if (act_vec() !== exp_vec() || FILLED !== (i == 7) ||
                EM_TRIG !== 1'b1 || EM_IN !== 1'b1 || OUT !== 1'b1)
                $display("FAIL fill_%0d got %b want %b", i, act_vec(), exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_hold_filled();
        for (int i = 0; i < 6; i++) begin
            cyc(1, 0, 0, 2'($urandom_range(1, 3)), 1);
            n_chk++;
            if (OUT !== 1'b1 || HOLD !== 1'b1 || SEL !== NS'(exp_sel()) ||
                act_vec() !== exp_vec())
                $display("FAIL hold_filled_%0d got %b want %b",
                         i, act_vec(), exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            bit en, init, llr, emo;
            logic [DV-2:0] inb;
            en   = ($urandom_range(0, 3) != 0);
            init = ($urandom_range(0, 39) == 0);
            llr  = 1'($urandom);
            emo  = 1'($urandom);
            inb  = $urandom_range(0, 1) ? {(DV-1){llr}} : 2'($urandom);
            cyc(en, init, llr, inb, emo);
            n_chk++;
            if (act_vec() !== exp_vec()) begin
                if (bad < 10)
                    $display("FAIL random_%0d got %b want %b",
                             i, act_vec(), exp_vec());
                bad++;
            end else n_pass++;
`ifdef VN_EDGE_HOLD_STAT_EN
            n_chk++;
            if (HOLD_CNT !== 16'(m_hcnt))
                $display("FAIL random_hcnt_%0d got %0d want %0d",
                         i, HOLD_CNT, m_hcnt);
            else n_pass++;
`endif
        end
    endtask

    task automatic test_init();
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, 2'b00, 0);
        cyc(1, 0, 1, 2'b01, 1);
        cyc(1, 1, 1, 2'b11, 0);
        n_chk++;
        if (FILLED !== 1'b0 || OUT !== 1'b0 || SEL !== 3'b101 ||
            act_vec() !== exp_vec())
            $display("FAIL init got %b want %b", act_vec(), exp_vec());
        else n_pass++;
`ifdef VN_EDGE_HOLD_STAT_EN
        n_chk++;
        if (HOLD_CNT !== 16'd0)
            $display("FAIL init_hcnt got %0d want 0", HOLD_CNT);
        else n_pass++;
`endif
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 9; i++) cyc(1, 0, 1, 2'b11, 0);
        n_chk++;
        if (EM_TRIG !== 1'b1 || FILLED !== 1'b1)
            $display("FAIL pre_reset got trig=%b filled=%b want 1 1",
                     EM_TRIG, FILLED);
        else n_pass++;
        #2 RESET = 0;
        model_reset();
        #1;
        n_chk++;
        if (EM_TRIG !== 1'b0 || act_vec() !== exp_vec())
            $display("FAIL async_reset got %b want %b", act_vec(), exp_vec());
        else n_pass++;
        #1 RESET = 1;
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 2'b01, 1);
            n_chk++;
            if (OUT !== 1'b0 || act_vec() !== exp_vec())
                $display("FAIL post_reset_hold_%0d got %b want %b",
                         i, act_vec(), exp_vec());
            else n_pass++;
        end
`ifdef VN_EDGE_HOLD_STAT_EN
        n_chk++;
        if (HOLD_CNT !== 16'd3)
            $display("FAIL post_reset_hcnt got %0d want 3", HOLD_CNT);
        else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_hold_prefill();
        test_fill();
        test_hold_filled();
        test_random();
        test_init();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
